sm83_irq_responder: RTL

- Peripheral-side interrupt controller for the SM83 core.
- Latches interrupt requests from 5 sources into IF and masks them with IE.
- Presents a single irq line to the core.
- Answers the core's interrupt-acknowledge handshake: returns the vector for the highest-priority enabled request and clears its IF bit.

---
 rtl/sm83_irq_responder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/sm83_irq_responder.sv
// SM83 interrupt responder: latches rising edges of the peripheral request lines into IF,
// masks them with IE, raises irq, and answers the core's acknowledge handshake with the
// vector of the highest-priority pending source (bit 0 highest) while clearing that IF bit.
module sm83_irq_responder #(
    parameter int unsigned N_SRC      = 5,
    parameter logic [7:0]  VEC_BASE   = 8'h40,
    parameter int unsigned VEC_STRIDE = 8
) (
    input  logic             clk_i,
    input  logic             nreset_i,
    input  logic [N_SRC-1:0] src_i,
    input  logic             wr_en_i,
    input  logic             wr_sel_i,
    input  logic [7:0]       wr_data_i,
    output logic [7:0]       rd_if_o,
    output logic [7:0]       rd_ie_o,
    output logic             irq_o,
    input  logic             ack_req_i,
    output logic [7:0]       vector_o,
    output logic             ack_done_o
);

    typedef enum logic [1:0] {StIdle, StLatch, StVector, StWaitDrop} state_e;

    state_e             state_q, state_d;
    logic [N_SRC-1:0]   if_q, if_d;
    logic [N_SRC-1:0]   ie_q, ie_d;
    logic [N_SRC-1:0]   src_q;
    logic [2:0]         idx_q, idx_d;
    logic               cancel_q, cancel_d;
    logic [7:0]         vector_q, vector_d;

    logic [N_SRC-1:0]   pend;
    logic [N_SRC-1:0]   rise;
    logic [N_SRC-1:0]   if_base;
    logic [N_SRC-1:0]   clr_mask;
    logic [2:0]         first_idx;
    logic [7:0]         vec_calc;
    logic               clear_en;

    // Only the low N_SRC data bits are architectural; the rest are ignored.
    logic unused_wr_data;
    assign unused_wr_data = ^wr_data_i;

    assign pend     = if_q & ie_q;
    assign rise     = src_i & ~src_q;
    assign irq_o    = |pend;
    assign clr_mask = N_SRC'(1) << idx_q;
    assign vec_calc = VEC_BASE + 8'(VEC_STRIDE * 32'(idx_q));
    assign vector_o = vector_q;

    // Readback: unused IF bits read as 1, unused IE bits read as 0.
    always_comb begin
        rd_if_o              = 8'hFF;
        rd_if_o[N_SRC-1:0]   = if_q;
        rd_ie_o              = 8'h00;
        rd_ie_o[N_SRC-1:0]   = ie_q;
    end

    // Priority encoder: index of the lowest set pending bit (0 when nothing pends).
    always_comb begin
        first_idx = 3'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (pend[i]) begin
                first_idx = 3'(i);
            end
        end
    end

    // Register next values: write, then acknowledge clear, then new edges (set wins).
    always_comb begin
        if_base = (wr_en_i && !wr_sel_i) ? wr_data_i[N_SRC-1:0] : if_q;
        if (clear_en) begin
            if_base = if_base & ~clr_mask;
        end
        if_d = if_base | rise;
        ie_d = (wr_en_i && wr_sel_i) ? wr_data_i[N_SRC-1:0] : ie_q;
    end

    // Acknowledge FSM next-state and outputs.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cancel_d   = cancel_q;
        vector_d   = vector_q;
        clear_en   = 1'b0;
        ack_done_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ack_req_i) begin
                    state_d  = StLatch;
                    idx_d    = first_idx;
                    cancel_d = (pend == '0);
                end
            end
            StLatch: begin
                state_d  = StVector;
                // Vector is prepared here so it is stable for the whole ack_done cycle.
                vector_d = cancel_q ? 8'h00 : vec_calc;
            end
            StVector: begin
                ack_done_o = 1'b1;
                clear_en   = !cancel_q;
                state_d    = StWaitDrop;
            end
            StWaitDrop: begin
                if (!ack_req_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!nreset_i) begin
            state_q  <= StIdle;
            if_q     <= '0;
            ie_q     <= '0;
            src_q    <= src_i;
            idx_q    <= 3'd0;
            cancel_q <= 1'b0;
            vector_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            if_q     <= if_d;
            ie_q     <= ie_d;
            src_q    <= src_i;
            idx_q    <= idx_d;
            cancel_q <= cancel_d;
            vector_q <= vector_d;
        end
    end

endmodule
